// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : link_pkg
//  Description : Shared constants and types for the NoC link message path.
//                Used by the message injector and by the link fault-injector
//                parser so both agree on the packet layout:
//                HEADER, SIZE, SERVICE, PROD, CONS, SRCPE, TIMESTAMP, payload.
//  Contents    : flit_pos_e               flit-position encoding
//                SERVICE_MESSAGE_DELIVERY service code of MESSAGE_DELIVERY
//                SIZE_FIXED_FIELDS        flits counted by SIZE before payload
//                clamp_len()              payload length saturation helper
//  Revision    : 1.0  initial release
// ============================================================================
package link_pkg;

   // Flit position inside a packet. IDLE means no packet on the link.
   typedef enum logic [3:0] {
      FP_IDLE      = 4'd0,
      FP_HEADER    = 4'd1,
      FP_SIZE      = 4'd2,
      FP_SERVICE   = 4'd3,
      FP_PROD      = 4'd4,
      FP_CONS      = 4'd5,
      FP_SRCPE     = 4'd6,
      FP_TIMESTAMP = 4'd7,
      FP_PAYLOAD   = 4'd8
   } flit_pos_e;

   localparam logic [31:0] SERVICE_MESSAGE_DELIVERY = 32'h0000_0001;

   // SIZE flit counts SERVICE, PROD, CONS, SRCPE, TIMESTAMP plus payload.
   localparam logic [31:0] SIZE_FIXED_FIELDS = 32'd5;

   // Saturate a requested payload length to the configured maximum.
   function automatic logic [7:0] clamp_len(input logic [7:0] len,
                                            input logic [7:0] max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage : link_pkg
`default_nettype wire

// File: rtl/link_msg_injector_if.sv
`default_nettype none
// ============================================================================
//  Module      : link_msg_injector_if
//  Description : Request handshake and flit transmit bus of the link message
//                injector.
//  Signals     : req_valid_i   packet request valid
//                req_ready_o   request accepted on valid && ready
//                req_target_i  destination address {x,y}
//                req_prod_i    producer id
//                req_cons_i    consumer id
//                req_len_i     requested payload words
//                tx_o          flit valid
//                cr_tx_i       downstream credit (transfer on tx_o && cr_tx_i)
//                eop_tx_o      last flit of packet
//                data_tx_o     flit data
//  Modports    : master  - the injector (drives ready and the tx side)
//                slave   - the requester / downstream link
//  Revision    : 1.0  initial release
// ============================================================================
interface link_msg_injector_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic [15:0] req_target_i;
   logic [31:0] req_prod_i;
   logic [31:0] req_cons_i;
   logic [7:0]  req_len_i;
   logic        tx_o;
   logic        cr_tx_i;
   logic        eop_tx_o;
   logic [31:0] data_tx_o;

   modport master (
      input  req_valid_i,
      input  req_target_i,
      input  req_prod_i,
      input  req_cons_i,
      input  req_len_i,
      input  cr_tx_i,
      output req_ready_o,
      output tx_o,
      output eop_tx_o,
      output data_tx_o
   );

   modport slave (
      output req_valid_i,
      output req_target_i,
      output req_prod_i,
      output req_cons_i,
      output req_len_i,
      output cr_tx_i,
      input  req_ready_o,
      input  tx_o,
      input  eop_tx_o,
      input  data_tx_o
   );

endinterface : link_msg_injector_if
`default_nettype wire

// File: rtl/link_msg_injector.sv
`default_nettype none
// ============================================================================
//  Module      : link_msg_injector
//  Description : Credit-based MESSAGE_DELIVERY packet source for a NoC link.
//                On each accepted request it emits, one flit per credited
//                cycle: HEADER, SIZE, SERVICE, PROD, CONS, SRCPE, TIMESTAMP
//                and len_c payload words, with eop on the last flit.
//  Parameters  : ADDRESS       own PE address, sent in the SRCPE flit
//                MAX_PAYLOAD   payload words are clamped to this value
//                PAYLOAD_SEED  payload word i = PAYLOAD_SEED + i
//  Ports       : clk_i         clock
//                rst_ni        synchronous reset, active low
//                bus           request handshake + flit tx (master modport)
//                busy_o        packet in flight
//                sent_count_o  packets whose eop flit has transferred (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module link_msg_injector
   import link_pkg::*;
#(
   parameter logic [15:0] ADDRESS      = 16'h0000,
   parameter logic [7:0]  MAX_PAYLOAD  = 8'd255,
   parameter logic [31:0] PAYLOAD_SEED = 32'hA5A5_0000
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   link_msg_injector_if.master        bus,
   output logic                       busy_o,
   output logic [31:0]                sent_count_o
);

   // State encoding mirrors the shared flit-position enum so that the
   // fault-injector parser and this source number flits identically.
   localparam logic [3:0] ST_IDLE      = FP_IDLE;
   localparam logic [3:0] ST_HEADER    = FP_HEADER;
   localparam logic [3:0] ST_SIZE      = FP_SIZE;
   localparam logic [3:0] ST_SERVICE   = FP_SERVICE;
   localparam logic [3:0] ST_PROD      = FP_PROD;
   localparam logic [3:0] ST_CONS      = FP_CONS;
   localparam logic [3:0] ST_SRCPE     = FP_SRCPE;
   localparam logic [3:0] ST_TIMESTAMP = FP_TIMESTAMP;
   localparam logic [3:0] ST_PAYLOAD   = FP_PAYLOAD;

   logic [3:0]  r_state;
   logic [15:0] r_target;
   logic [31:0] r_prod;
   logic [31:0] r_cons;
   logic [7:0]  r_len;
   logic [31:0] r_ts;
   logic [7:0]  r_idx;
   logic [31:0] r_cycle;
   logic [31:0] r_sent;
   logic        r_busy;

   logic [3:0]  w_state_nxt;
   logic        w_accept;
   logic        w_xfer;
   logic        w_last;
   logic [31:0] w_data;

   assign w_accept = (r_state == ST_IDLE) && bus.req_valid_i;
   assign w_xfer   = (r_state != ST_IDLE) && bus.cr_tx_i;

   // Last flit is TIMESTAMP for an empty packet, otherwise the final payload
   // word. r_len is never 0 while in PAYLOAD, so r_len-1 cannot underflow
   // in a way that matters.
   assign w_last = ((r_state == ST_TIMESTAMP) && (r_len == 8'd0)) ||
                   ((r_state == ST_PAYLOAD) && (r_idx == (r_len - 8'd1)));

   // ---------------------------------------------------------------------
   // Next-state logic: every non-idle state advances only on a transfer.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (w_accept) w_state_nxt = ST_HEADER;
         ST_HEADER:    if (w_xfer)   w_state_nxt = ST_SIZE;
         ST_SIZE:      if (w_xfer)   w_state_nxt = ST_SERVICE;
         ST_SERVICE:   if (w_xfer)   w_state_nxt = ST_PROD;
         ST_PROD:      if (w_xfer)   w_state_nxt = ST_CONS;
         ST_CONS:      if (w_xfer)   w_state_nxt = ST_SRCPE;
         ST_SRCPE:     if (w_xfer)   w_state_nxt = ST_TIMESTAMP;
         ST_TIMESTAMP: if (w_xfer)   w_state_nxt = w_last ? ST_IDLE : ST_PAYLOAD;
         ST_PAYLOAD:   if (w_xfer && w_last) w_state_nxt = ST_IDLE;
         default:                    w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Flit mux. Driven purely from registered state and latched fields, so
   // data and eop hold steady while the downstream withholds credit.
   // ---------------------------------------------------------------------
   always_comb begin
      w_data = 32'h0;
      case (r_state)
         ST_HEADER:    w_data = {16'h0, r_target};
         ST_SIZE:      w_data = SIZE_FIXED_FIELDS + {24'h0, r_len};
         ST_SERVICE:   w_data = SERVICE_MESSAGE_DELIVERY;
         ST_PROD:      w_data = r_prod;
         ST_CONS:      w_data = r_cons;
         ST_SRCPE:     w_data = {16'h0, ADDRESS};
         ST_TIMESTAMP: w_data = r_ts;
         ST_PAYLOAD:   w_data = PAYLOAD_SEED + {24'h0, r_idx};
         default:      w_data = 32'h0;
      endcase
   end

   // ---------------------------------------------------------------------
   // State, request latch and counters.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_target <= 16'h0;
         r_prod   <= 32'h0;
         r_cons   <= 32'h0;
         r_len    <= 8'h0;
         r_ts     <= 32'h0;
         r_idx    <= 8'h0;
         r_cycle  <= 32'h0;
         r_sent   <= 32'h0;
         r_busy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_cycle <= r_cycle + 32'd1;

         // Request fields are captured once; later req_* changes are ignored.
         if (w_accept) begin
            r_target <= bus.req_target_i;
            r_prod   <= bus.req_prod_i;
            r_cons   <= bus.req_cons_i;
            r_len    <= clamp_len(bus.req_len_i, MAX_PAYLOAD);
            r_ts     <= r_cycle;
            r_idx    <= 8'h0;
         end else if (w_xfer && (r_state == ST_PAYLOAD)) begin
            r_idx <= r_idx + 8'd1;
         end

         if (w_xfer && w_last) begin
            r_sent <= r_sent + 32'd1;
         end
      end
   end

   assign bus.req_ready_o = (r_state == ST_IDLE);
   assign bus.tx_o        = (r_state != ST_IDLE);
   assign bus.eop_tx_o    = w_last;
   assign bus.data_tx_o   = w_data;
   assign busy_o          = r_busy;
   assign sent_count_o    = r_sent;

endmodule : link_msg_injector
`default_nettype wire

// File: tb/tb_link_msg_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_link_msg_injector
//  Description : Self-checking bench for link_msg_injector. A packet-level
//                model (queue of expected flits) is compared against the DUT
//                after every clock; directed literal checks pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_link_msg_injector;
   import link_pkg::*;

   localparam logic [15:0] ADDR = 16'h0203;
   localparam logic [7:0]  MAXP = 8'd4;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        busy_o;
   logic [31:0] sent_count_o;

   always #5 clk_i = ~clk_i;

   link_msg_injector_if bus_if ();

   link_msg_injector #(
      .ADDRESS      (ADDR),
      .MAX_PAYLOAD  (MAXP),
      .PAYLOAD_SEED (SEED)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .bus          (bus_if),
      .busy_o       (busy_o),
      .sent_count_o (sent_count_o)
   );

   typedef struct packed {
      logic        eop;
      logic [31:0] data;
   } flit_t;

   typedef struct packed {
      logic        eop;
      logic [31:0] data;
      logic [31:0] cyc;
   } cap_t;

   flit_t       exp_q[$];
   cap_t        cap_q[$];
   logic [31:0] m_cycle = 32'h0;
   logic [31:0] m_sent  = 32'h0;
   logic [31:0] tcyc    = 32'h0;
   int          eop_cnt = 0;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tcyc);
      end
   endtask

   // Expected packet as a flat list of flits.
   task automatic build_packet(input logic [15:0] tgt, input logic [31:0] prod,
                               input logic [31:0] cons, input logic [7:0] len,
                               input logic [31:0] ts);
      int lc;
      lc = (len > MAXP) ? int'(MAXP) : int'(len);
      exp_q.push_back('{eop: 1'b0, data: {16'h0, tgt}});
      exp_q.push_back('{eop: 1'b0, data: 32'(5 + lc)});
      exp_q.push_back('{eop: 1'b0, data: 32'h1});
      exp_q.push_back('{eop: 1'b0, data: prod});
      exp_q.push_back('{eop: 1'b0, data: cons});
      exp_q.push_back('{eop: 1'b0, data: {16'h0, ADDR}});
      exp_q.push_back('{eop: (lc == 0), data: ts});
      for (int i = 0; i < lc; i++)
         exp_q.push_back('{eop: (i == lc - 1), data: SEED + 32'(i)});
   endtask

   // Model update for one rising edge, using the inputs present at the edge.
   task automatic model_edge();
      flit_t f;
      if (!rst_ni) begin
         exp_q.delete();
         m_cycle = 32'h0;
         m_sent  = 32'h0;
      end else begin
         if (exp_q.size() != 0) begin
            if (bus_if.cr_tx_i) begin
               f = exp_q.pop_front();
               if (f.eop) m_sent++;
            end
         end else if (bus_if.req_valid_i) begin
            build_packet(bus_if.req_target_i, bus_if.req_prod_i, bus_if.req_cons_i,
                         bus_if.req_len_i, m_cycle);
         end
         m_cycle++;
      end
   endtask

   task automatic compare();
      logic        e_tx;
      logic [31:0] e_data;
      logic        e_eop;
      e_tx   = (exp_q.size() != 0);
      e_data = e_tx ? exp_q[0].data : 32'h0;
      e_eop  = e_tx ? exp_q[0].eop  : 1'b0;
      chk("model tx_o",         32'(bus_if.tx_o),        32'(e_tx));
      chk("model req_ready_o",  32'(bus_if.req_ready_o), 32'(!e_tx));
      chk("model busy_o",       32'(busy_o),             32'(e_tx));
      chk("model data_tx_o",    bus_if.data_tx_o,        e_data);
      chk("model eop_tx_o",     32'(bus_if.eop_tx_o),    32'(e_eop));
      chk("model sent_count_o", sent_count_o,            m_sent);
   endtask

   // One clock: record a transfer about to happen, apply the edge to the
   // model, then compare at the falling edge.
   task automatic tick();
      if (rst_ni === 1'b1 && bus_if.tx_o === 1'b1 && bus_if.cr_tx_i === 1'b1) begin
         cap_q.push_back('{eop: bus_if.eop_tx_o, data: bus_if.data_tx_o, cyc: tcyc});
         if (bus_if.eop_tx_o) eop_cnt++;
      end
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      tcyc++;
      compare();
   endtask

   task automatic clear_cap();
      cap_q.delete();
      eop_cnt = 0;
   endtask

   task automatic issue(input logic [15:0] tgt, input logic [31:0] prod,
                        input logic [31:0] cons, input logic [7:0] len);
      bus_if.req_target_i = tgt;
      bus_if.req_prod_i   = prod;
      bus_if.req_cons_i   = cons;
      bus_if.req_len_i    = len;
      bus_if.req_valid_i  = 1'b1;
      tick();
      bus_if.req_valid_i  = 1'b0;
   endtask

   task automatic run_until(input string name, input int target, input int bound,
                            input bit toggle_cr);
      for (int k = 0; k < bound && eop_cnt < target; k++) begin
         if (toggle_cr) bus_if.cr_tx_i = (k % 2 == 0);
         tick();
      end
      bus_if.cr_tx_i = 1'b1;
      chk({name, " packets completed within bound"}, 32'(eop_cnt), 32'(target));
   endtask

   initial begin
      rst_ni              = 1'b0;
      bus_if.req_valid_i  = 1'b0;
      bus_if.req_target_i = 16'h0;
      bus_if.req_prod_i   = 32'h0;
      bus_if.req_cons_i   = 32'h0;
      bus_if.req_len_i    = 8'h0;
      bus_if.cr_tx_i      = 1'b1;

      // T1 reset
      tick();
      tick();
      chk("T1 tx_o",         32'(bus_if.tx_o),        32'h0);
      chk("T1 eop_tx_o",     32'(bus_if.eop_tx_o),    32'h0);
      chk("T1 data_tx_o",    bus_if.data_tx_o,        32'h0);
      chk("T1 req_ready_o",  32'(bus_if.req_ready_o), 32'h1);
      chk("T1 busy_o",       32'(busy_o),             32'h0);
      chk("T1 sent_count_o", sent_count_o,            32'h0);
      rst_ni = 1'b1;

      // T2 empty packet, full credit
      clear_cap();
      issue(16'h0102, 32'h0100, 32'h0101, 8'd0);
      run_until("T2", 1, 20, 1'b0);
      chk("T2 flit count", 32'(cap_q.size()), 32'd7);
      chk("T2 HEADER",  cap_q[0].data, 32'h0000_0102);
      chk("T2 SIZE",    cap_q[1].data, 32'd5);
      chk("T2 SERVICE", cap_q[2].data, 32'h1);
      chk("T2 PROD",    cap_q[3].data, 32'h0000_0100);
      chk("T2 CONS",    cap_q[4].data, 32'h0000_0101);
      chk("T2 SRCPE",   cap_q[5].data, 32'h0000_0203);
      chk("T2 TIMESTAMP", cap_q[6].data, 32'h0);
      for (int i = 0; i < 7; i++)
         chk("T2 eop position", 32'(cap_q[i].eop), 32'(i == 6));
      chk("T2 sent_count_o", sent_count_o, 32'd1);

      // T3 three payload words, credit toggling
      clear_cap();
      issue(16'h0304, 32'h0200, 32'h0201, 8'd3);
      run_until("T3", 1, 40, 1'b1);
      chk("T3 flit count", 32'(cap_q.size()), 32'd10);
      chk("T3 SIZE",       cap_q[1].data, 32'd8);
      chk("T3 payload 0",  cap_q[7].data, 32'hA5A5_0000);
      chk("T3 payload 1",  cap_q[8].data, 32'hA5A5_0001);
      chk("T3 payload 2",  cap_q[9].data, 32'hA5A5_0002);
      chk("T3 eop 9th",    32'(cap_q[8].eop), 32'h0);
      chk("T3 eop 10th",   32'(cap_q[9].eop), 32'h1);
      chk("T3 transfer span", cap_q[9].cyc - cap_q[0].cyc, 32'd18);
      chk("T3 sent_count_o", sent_count_o, 32'd2);

      // T4 length clamped to MAX_PAYLOAD
      clear_cap();
      issue(16'h0405, 32'h0300, 32'h0301, 8'd9);
      run_until("T4", 1, 30, 1'b0);
      chk("T4 flit count",  32'(cap_q.size()), 32'd11);
      chk("T4 SIZE",        cap_q[1].data, 32'd9);
      chk("T4 last payload", cap_q[10].data, 32'hA5A5_0003);
      chk("T4 eop last",    32'(cap_q[10].eop), 32'h1);

      // T5 reset while PROD is on the bus
      clear_cap();
      issue(16'h0506, 32'h0400, 32'h0401, 8'd2);
      tick();
      tick();
      tick();
      chk("T5 PROD on bus", bus_if.data_tx_o, 32'h0000_0400);
      rst_ni = 1'b0;
      tick();
      chk("T5 tx_o after reset",      32'(bus_if.tx_o),        32'h0);
      chk("T5 req_ready_o after reset", 32'(bus_if.req_ready_o), 32'h1);
      chk("T5 sent_count_o after reset", sent_count_o,          32'h0);
      rst_ni = 1'b1;
      clear_cap();
      issue(16'h0708, 32'h0500, 32'h0501, 8'd0);
      chk("T5 restart HEADER", bus_if.data_tx_o, 32'h0000_0708);
      run_until("T5", 1, 20, 1'b0);
      chk("T5 restart flit count", 32'(cap_q.size()), 32'd7);
      chk("T5 sent_count_o", sent_count_o, 32'd1);

      // T6 back-to-back requests with req_valid_i held high
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      clear_cap();
      bus_if.req_target_i = 16'h0900;
      bus_if.req_prod_i   = 32'h0600;
      bus_if.req_cons_i   = 32'h0601;
      bus_if.req_len_i    = 8'd1;
      bus_if.req_valid_i  = 1'b1;
      run_until("T6", 2, 40, 1'b0);
      bus_if.req_valid_i  = 1'b0;
      chk("T6 flit count",       32'(cap_q.size()), 32'd16);
      chk("T6 first eop",        32'(cap_q[7].eop), 32'h1);
      chk("T6 second HEADER",    cap_q[8].data, 32'h0000_0900);
      chk("T6 idle gap",         cap_q[8].cyc - cap_q[7].cyc, 32'd2);
      chk("T6 timestamp delta",  cap_q[14].data - cap_q[6].data, 32'd9);
      chk("T6 second eop",       32'(cap_q[15].eop), 32'h1);
      chk("T6 sent_count_o",     sent_count_o, 32'd2);

      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_link_msg_injector
`default_nettype wire
